// File: rtl/bram_test_seq_pkg.sv
// Shared encodings, FSM state type, LFSR taps and pattern helpers for the BRAM test sequencer.
package bts_pkg;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK_LAST,
    ST_DONE
  } bts_state_e;

  // Galois (right-shift) masks for maximal-length sequences
  localparam logic [31:0] LFSR_TAP8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAP16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAP32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_tap(input int width);
    case (width)
      8:       lfsr_tap = LFSR_TAP8;
      32:      lfsr_tap = LFSR_TAP32;
      default: lfsr_tap = LFSR_TAP16;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l, input int width);
    lfsr_next = l >> 1;
    if (l[0]) lfsr_next = lfsr_next ^ lfsr_tap(width);
  endfunction

  function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] i,
                                      input logic [31:0] l, input int width);
    logic [4:0] sh;
    sh = i[4:0] & 5'(width - 1);
    case (m)
      MODE_INC:   pat = i;
      MODE_WALK:  pat = 32'd1 << sh;
      MODE_CHECK: pat = i[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default:    pat = l;
    endcase
  endfunction

endpackage

// File: rtl/bram_test_seq_if.sv
// BRAM dual-port bus between the test sequencer (master) and the memory (slave).
interface bram_test_seq_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
);
   logic              en_a;
   logic              we_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] din_a;
   logic              en_b;
   logic              we_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] dout_b;

   modport master (output en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, input dout_b);
   modport slave  (input en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, output dout_b);
endinterface

// File: rtl/bram_test_seq_tick_gen.sv
// Step enable for the sequencer: one-cycle tick every 2**STEP_LOG2 clocks (every clock when 0).
module bts_tick_gen #(
   parameter int STEP_LOG2 = 22
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   generate
      if (STEP_LOG2 == 0) begin : g_always
         logic unused_clk;
         assign unused_clk = clk ^ rst_n;
         assign tick       = 1'b1;
      end else begin : g_div
         logic [STEP_LOG2-1:0] cnt;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else        cnt <= cnt + 1'b1;
         end
         assign tick = &cnt;
      end
   endgenerate

endmodule

// File: rtl/bram_test_seq.sv
// BRAM write/readback test sequencer: fill via port A with a pattern, read back via port B, count mismatches.
// Optional macro BTS_ERR_INJECT_EN adds an 'inject' input that corrupts bit 0 of the address-0 write.
module bram_test_seq
   import bts_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 9,
   parameter int STEP_LOG2 = 22,
   parameter int ERRC_W    = 8,
   parameter int SEED      = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              loop,
   input  logic [1:0]        mode,
`ifdef BTS_ERR_INJECT_EN
   input  logic              inject,
`endif
   bram_test_seq_if.master   bram,
   output logic              busy,
   output logic              done,
   output logic              ok_led,
   output logic [DATA_W-1:0] last_value,
   output logic [ERRC_W-1:0] err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [ADDR_W-1:0] LAST   = '1;
   localparam logic [DATA_W-1:0] SEED_V = SEED[DATA_W-1:0];

   bts_state_e        state, state_n;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] lfsr;
   logic              tick, launch, wr, rd, inj;
   logic              chk_pend;
   logic [DATA_W-1:0] exp_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       pat_full, lfsr_nx;
   logic [DATA_W-1:0] pat_w;
   logic              unused_hi;

   bts_tick_gen #(.STEP_LOG2(STEP_LOG2)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign pat_full  = pat(mode_q, 32'(idx), 32'(lfsr), DATA_W);
   assign lfsr_nx   = lfsr_next(32'(lfsr), DATA_W);
   assign pat_w     = pat_full[DATA_W-1:0];
   assign unused_hi = ^{pat_full, lfsr_nx};

`ifdef BTS_ERR_INJECT_EN
   assign inj = wr && (idx == '0) && inject;
`else
   assign inj = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Start leaves IDLE/DONE at once; the first write then waits for the next tick.
   always_comb begin
      state_n = state;
      launch  = 1'b0;
      wr      = 1'b0;
      rd      = 1'b0;
      unique case (state)
         ST_IDLE: if (start) begin
            launch  = 1'b1;
            state_n = ST_WRITE;
         end
         ST_WRITE: if (tick) begin
            wr = 1'b1;
            if (idx == LAST) state_n = ST_READ;
         end
         ST_READ: if (tick) begin
            rd = 1'b1;
            if (idx == LAST) state_n = ST_CHECK_LAST;
         end
         ST_CHECK_LAST: state_n = ST_DONE;
         ST_DONE: if (start || loop) begin
            launch  = 1'b1;
            state_n = ST_WRITE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // idx wraps LAST->0 naturally on the final write/read, which is also the state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= MODE_INC;
         idx      <= '0;
         lfsr     <= SEED_V;
         chk_pend <= 1'b0;
         exp_q    <= '0;
         addr_q   <= '0;
      end else begin
         chk_pend <= rd;
         if (launch) begin
            mode_q <= mode;
            idx    <= '0;
            lfsr   <= SEED_V;
         end else if (wr) begin
            idx  <= idx + 1'b1;
            lfsr <= (idx == LAST) ? SEED_V : lfsr_nx[DATA_W-1:0];
         end else if (rd) begin
            idx    <= idx + 1'b1;
            lfsr   <= lfsr_nx[DATA_W-1:0];
            exp_q  <= pat_w;
            addr_q <= idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_value     <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (launch) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (chk_pend) begin
         last_value <= bram.dout_b;
         if (bram.dout_b != exp_q) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_addr <= addr_q;
         end
      end
   end

   assign bram.en_a   = wr;
   assign bram.we_a   = wr;
   assign bram.addr_a = idx;
   assign bram.din_a  = wr ? (pat_w ^ {{(DATA_W-1){1'b0}}, inj}) : '0;
   assign bram.en_b   = rd;
   assign bram.we_b   = 1'b0;
   assign bram.addr_b = idx;

   assign busy   = (state == ST_WRITE) || (state == ST_READ);
   assign done   = (state == ST_DONE);
   assign ok_led = done && (err_count == '0);

endmodule

// File: tb/tb_bram_test_seq.sv
// Bench for bram_test_seq: behavioural BRAM, write/read scoreboard, scenario tasks.
module tb_bram_test_seq;
  localparam int DW = 16, AW = 5, DEPTH = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, loop = 1'b0, start2 = 1'b0;
  logic [1:0] mode = 2'd0;
`ifdef BTS_ERR_INJECT_EN
  logic inject = 1'b0, inject2 = 1'b0;
`endif
  logic busy, done, ok_led;
  logic [DW-1:0] last_value;
  logic [7:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic busy2, done2, ok2;
  logic [7:0] last2, err2;
  logic [2:0] ferr2;

  int n_cmp = 0, n_bad = 0;
  bit sb_on = 1'b0;
  int corrupt_addr = -1;
  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] mem[DEPTH];
  logic [DW-1:0] dout_r = '0;
  logic [7:0] mem2[8];
  logic [7:0] dout2_r = '0;

  bram_test_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  bram_test_seq_if #(.DATA_W(8), .ADDR_W(3)) bus2();
  assign bus.dout_b  = dout_r;
  assign bus2.dout_b = dout2_r;

  bram_test_seq #(.DATA_W(DW), .ADDR_W(AW), .STEP_LOG2(0), .ERRC_W(8), .SEED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .mode(mode),
`ifdef BTS_ERR_INJECT_EN
    .inject(inject),
`endif
    .bram(bus), .busy(busy), .done(done), .ok_led(ok_led), .last_value(last_value),
    .err_count(err_count), .first_err_addr(first_err_addr));

  bram_test_seq #(.DATA_W(8), .ADDR_W(3), .STEP_LOG2(2), .ERRC_W(8), .SEED(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .loop(1'b0), .mode(2'd0),
`ifdef BTS_ERR_INJECT_EN
    .inject(inject2),
`endif
    .bram(bus2), .busy(busy2), .done(done2), .ok_led(ok2), .last_value(last2),
    .err_count(err2), .first_err_addr(ferr2));

  always #5 clk = ~clk;

  // Behavioural true dual-port BRAM, 1-cycle read latency; one address can be forced to read 0.
  always @(posedge clk) begin
    if (bus.en_a && bus.we_a) mem[bus.addr_a] <= bus.din_a;
    if (bus.en_b) dout_r <= (int'(bus.addr_b) == corrupt_addr) ? '0 : mem[bus.addr_b];
    if (bus2.en_a && bus2.we_a) mem2[bus2.addr_a] <= bus2.din_a;
    if (bus2.en_b) dout2_r <= mem2[bus2.addr_b];
  end

  // Scoreboard: every port-A write and port-B read issue is popped against the expected stream.
  always @(negedge clk) begin : sb_mon
    logic [AW+DW-1:0] e;
    logic [AW-1:0] ea;
    if (sb_on && bus.en_a) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++; $display("FAIL sb_wr unexpected write a=%0d d=%h", bus.addr_a, bus.din_a);
      end else begin
        e = wr_q.pop_front();
        if (bus.we_a !== 1'b1 || {bus.addr_a, bus.din_a} !== e) begin
          n_bad++;
          $display("FAIL sb_wr got we=%b a=%0d d=%h want a=%0d d=%h",
                   bus.we_a, bus.addr_a, bus.din_a, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (sb_on && bus.en_b) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++; $display("FAIL sb_rd unexpected read a=%0d", bus.addr_b);
      end else begin
        ea = rd_q.pop_front();
        if (bus.we_b !== 1'b0 || bus.addr_b !== ea) begin
          n_bad++; $display("FAIL sb_rd got we=%b a=%0d want a=%0d", bus.we_b, bus.addr_b, ea);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push_run(input int m, input bit inj, output logic [DW-1:0] last);
    logic [DW-1:0] l, d;
    l = 16'd1;
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      case (m)
        0: d = 16'(i);
        1: d = 16'd1 << (i % 16);
        2: d = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
        default: d = l;
      endcase
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      if (i == DEPTH - 1) last = d;
      if (inj && i == 0) d[0] = ~d[0];
      wr_q.push_back({AW'(i), d});
      rd_q.push_back(AW'(i));
    end
  endtask

  // Pulses start and counts clock edges until done (bounded; 400 means the bound expired).
  task automatic run(output int cyc);
    start = 1'b1;
    cyc = 0;
    @(posedge clk); cyc++; #1 start = 1'b0;
    while (!done && cyc < 400) begin @(posedge clk); cyc++; #1; end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({bus.en_a, bus.we_a, bus.addr_a, bus.din_a, bus.en_b, bus.we_b, bus.addr_b, busy, done,
         ok_led, last_value, err_count, first_err_addr} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got nonzero en_a=%b din_a=%h busy=%b done=%b last=%h",
                        bus.en_a, bus.din_a, busy, done, last_value);
    end
    n_cmp++;
    if ({bus2.en_a, bus2.din_a, bus2.en_b, busy2, done2, ok2, last2, err2, ferr2} !== '0) begin
      n_bad++; $display("FAIL reset_outputs2 got nonzero");
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sb_on = 1'b1;
  endtask

  task automatic test_inc();
    int cyc; logic [DW-1:0] last;
    push_run(0, 1'b0, last);
    mode = 2'd0;
    run(cyc);
    n_cmp++; if (cyc !== 66) begin n_bad++; $display("FAIL inc_latency got %0d want 66", cyc); end
    n_cmp++; if (ok_led !== 1'b1 || err_count !== 8'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL inc_status got ok=%b err=%0d busy=%b want 1 0 0", ok_led, err_count, busy); end
    n_cmp++; if (last_value !== 16'd31) begin
      n_bad++; $display("FAIL inc_last got %h want 001f", last_value); end
    n_cmp++; if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++; $display("FAIL inc_sb_left got %0d/%0d want 0/0", wr_q.size(), rd_q.size()); end
  endtask

  task automatic test_walk();
    int cyc; logic [DW-1:0] last;
    push_run(1, 1'b0, last);
    mode = 2'd1;
    run(cyc);
    n_cmp++; if (mem[17] !== 16'h0002) begin
      n_bad++; $display("FAIL walk_addr17 got %h want 0002", mem[17]); end
    n_cmp++; if (ok_led !== 1'b1 || err_count !== 8'd0 || done !== 1'b1) begin
      n_bad++; $display("FAIL walk_status got ok=%b err=%0d done=%b", ok_led, err_count, done); end
    n_cmp++; if (last_value !== 16'h8000) begin
      n_bad++; $display("FAIL walk_last got %h want 8000", last_value); end
  endtask

  task automatic test_check();
    int cyc; logic [DW-1:0] last;
    push_run(2, 1'b0, last);
    mode = 2'd2;
    corrupt_addr = 3;
    run(cyc);
    corrupt_addr = -1;
    n_cmp++; if (done !== 1'b1 || err_count !== 8'd1) begin
      n_bad++; $display("FAIL check_err got done=%b err=%0d want 1 1", done, err_count); end
    n_cmp++; if (first_err_addr !== 5'd3) begin
      n_bad++; $display("FAIL check_first got %0d want 3", first_err_addr); end
    n_cmp++; if (ok_led !== 1'b0) begin
      n_bad++; $display("FAIL check_ok got %b want 0", ok_led); end
    n_cmp++; if (last_value !== 16'h5555) begin
      n_bad++; $display("FAIL check_last got %h want 5555", last_value); end
  endtask

  task automatic test_lfsr_loop();
    int cyc, ndone; logic [DW-1:0] last;
    push_run(3, 1'b0, last);
    push_run(3, 1'b0, last);
    mode = 2'd3; loop = 1'b1; start = 1'b1;
    cyc = 0; ndone = 0;
    while (ndone < 2 && cyc < 400) begin
      @(posedge clk); cyc++; #1;
      start = (cyc == 20);
      if (cyc == 30) mode = 2'd0;
      if (cyc == 40) mode = 2'd3;
      if (done) begin
        ndone++;
        n_cmp++;
        if (ok_led !== 1'b1 || err_count !== 8'd0 || last_value !== last) begin
          n_bad++; $display("FAIL lfsr_run%0d got ok=%b err=%0d last=%h want 1 0 %h",
                            ndone, ok_led, err_count, last_value, last);
        end
      end
      if (ndone == 1 && busy) loop = 1'b0;
    end
    loop = 1'b0;
    n_cmp++; if (cyc !== 132 || ndone !== 2) begin
      n_bad++; $display("FAIL lfsr_loop_len got cyc=%0d runs=%0d want 132 2", cyc, ndone); end
    n_cmp++; if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++; $display("FAIL lfsr_sb_left got %0d/%0d want 0/0", wr_q.size(), rd_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [DW-1:0] last;
    push_run(0, 1'b0, last);
    mode = 2'd0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (44) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1 || bus.en_b !== 1'b1) begin
      n_bad++; $display("FAIL rmid_in_read got busy=%b en_b=%b want 1 1", busy, bus.en_b); end
    sb_on = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.en_a, bus.we_a, bus.addr_a, bus.din_a, bus.en_b, bus.we_b, bus.addr_b, busy, done,
         ok_led, last_value, err_count, first_err_addr} !== '0) begin
      n_bad++; $display("FAIL rmid_async got en_b=%b addr_b=%0d busy=%b last=%h want all 0",
                        bus.en_b, bus.addr_b, busy, last_value);
    end
    wr_q.delete(); rd_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sb_on = 1'b1;
    push_run(0, 1'b0, last);
    run(cyc);
    n_cmp++; if (cyc !== 66 || ok_led !== 1'b1 || err_count !== 8'd0 || last_value !== 16'd31) begin
      n_bad++; $display("FAIL rmid_rerun got cyc=%0d ok=%b err=%0d last=%h want 66 1 0 001f",
                        cyc, ok_led, err_count, last_value);
    end
  endtask

  task automatic test_tick();
    int lat, gap, cyc;
    start2 = 1'b1; lat = 0;
    do begin @(posedge clk); lat++; #1 start2 = 1'b0; end while (!bus2.en_a && lat < 20);
    n_cmp++; if (lat < 1 || lat > 5) begin
      n_bad++; $display("FAIL tick_latency got %0d want 1..5", lat); end
    @(posedge clk); #1;
    n_cmp++; if (bus2.en_a !== 1'b0) begin
      n_bad++; $display("FAIL tick_pulse got en_a=%b want 0", bus2.en_a); end
    gap = 1;
    while (!bus2.en_a && gap < 20) begin @(posedge clk); gap++; #1; end
    n_cmp++; if (gap !== 4) begin
      n_bad++; $display("FAIL tick_spacing got %0d want 4", gap); end
    cyc = 0;
    while (!done2 && cyc < 500) begin @(posedge clk); cyc++; #1; end
    n_cmp++; if (done2 !== 1'b1 || ok2 !== 1'b1 || err2 !== 8'd0 || last2 !== 8'd7) begin
      n_bad++; $display("FAIL tick_run got done=%b ok=%b err=%0d last=%h want 1 1 0 07",
                        done2, ok2, err2, last2);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem2[i] !== 8'(i)) begin
        n_bad++; $display("FAIL tick_mem[%0d] got %h want %h", i, mem2[i], 8'(i)); end
    end
  endtask

`ifdef BTS_ERR_INJECT_EN
  task automatic test_inject();
    int cyc; logic [DW-1:0] last;
    push_run(0, 1'b1, last);
    mode = 2'd0; inject = 1'b1;
    run(cyc);
    inject = 1'b0;
    n_cmp++; if (err_count !== 8'd1 || first_err_addr !== 5'd0 || ok_led !== 1'b0) begin
      n_bad++; $display("FAIL inject_err got err=%0d first=%0d ok=%b want 1 0 0",
                        err_count, first_err_addr, ok_led);
    end
    n_cmp++; if (last_value !== 16'd31) begin
      n_bad++; $display("FAIL inject_last got %h want 001f", last_value); end
  endtask
`endif

  initial begin
    test_reset();
    test_inc();
    test_walk();
    test_check();
    test_lfsr_loop();
    test_reset_mid();
    test_tick();
`ifdef BTS_ERR_INJECT_EN
    test_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
